mw8080_memory_dl: RTL and testbench

- Parametrised successor to the per-game Midway/Taito 8080 memory blocks.
- N ROM banks of 2^BANK_AW bytes are loaded at runtime from the MiST download stream instead of hex init files.
- One CPU RAM, cleared by hardware after reset and after every download.
- Bank select is registered so ROM output is aligned with the synchronous BRAM data.
- Drives Hold to stall the 8080 core while loading or clearing.

---
 rtl/mw8080_mem_pkg.sv | 19 +
 rtl/mw_dpram_bank.sv | 27 ++
 rtl/mw8080_memory_dl.sv | 178 +++++++++++++++++
 tb/tb_mw8080_memory_dl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mw8080_mem_pkg.sv
// Shared types and helpers for the downloadable Midway/Taito 8080 memory block.
package mw8080_mem_pkg;

    // Memory controller phases: RAM clear, normal CPU run, ROM download
    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        LOAD
    } state_t;

    // Byte written to every RAM location while clearing
    localparam logic [7:0] CLEAR_VAL_DEF = 8'h00;

    // First byte address past the end of the ROM image
    function automatic int unsigned rom_top(input int unsigned banks, input int unsigned aw);
        return banks << aw;
    endfunction

endpackage

// File: rtl/mw_dpram_bank.sv
// Single-clock block RAM: one write port, one registered read port, 8-bit data.
// A read of the address being written returns the old byte (read-before-write).
module mw_dpram_bank #(
    parameter int unsigned AW = 11
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [2**AW];
    logic [7:0] r_rdata;

    // Array write and synchronous read; no reset so this maps onto BRAM
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mw8080_memory_dl.sv
// ROM/RAM block for the 8080 arcade cores. ROM banks are filled from the MiST
// download stream; the CPU RAM is hardware-cleared after reset and after every
// download. Hold stalls the CPU while loading or clearing.
module mw8080_memory_dl
    import mw8080_mem_pkg::*;
#(
    parameter int unsigned ROM_BANKS = 3,
    parameter int unsigned BANK_AW   = 11,
    parameter int unsigned RAM_AW    = 13,
    parameter logic [7:0]  CLEAR_VAL = CLEAR_VAL_DEF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RW_n,
    input  logic [15:0] Addr,
    input  logic [15:0] Ram_Addr,
    input  logic [7:0]  Ram_in,
    output logic [7:0]  Ram_out,
    output logic [7:0]  Rom_out,
    input  logic        dn_active,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        Hold,
    output logic        dn_ovf
);

    localparam int unsigned       ROM_TOP  = rom_top(ROM_BANKS, BANK_AW);
    localparam int unsigned       IDX_W    = 16 - BANK_AW;
    localparam logic [RAM_AW-1:0] CLR_LAST = '1;

    state_t              r_state;
    logic [RAM_AW-1:0]   r_clr_cnt;
    logic                r_hold;
    logic                r_dn_ovf;
    logic                r_rd_vld;
    logic [IDX_W-1:0]    r_rom_idx;

    logic                w_dn_oor;
    logic [ROM_BANKS-1:0] w_bank_we;
    logic [7:0]          w_rom_q [ROM_BANKS];
    logic [7:0]          w_rom_sel;
    logic                w_ram_we;
    logic [RAM_AW-1:0]   w_ram_waddr;
    logic [7:0]          w_ram_wdata;
    logic [7:0]          w_ram_q;
    logic                w_unused_ram_hi;

    // Upper RAM address bits are deliberately ignored so the RAM mirrors
    assign w_unused_ram_hi = ^Ram_Addr[15:RAM_AW];

    assign w_dn_oor = ({16'd0, dn_addr} >= ROM_TOP);

    // Controller FSM: clear sweep, run, download; Hold and overflow flag registered
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_hold    <= 1'b1;
            r_dn_ovf  <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (dn_active) begin
                        // A download start aborts the clear; it restarts afterwards
                        r_state  <= LOAD;
                        r_hold   <= 1'b1;
                        r_dn_ovf <= 1'b0;
                    end else if (r_clr_cnt == CLR_LAST) begin
                        r_state <= RUN;
                        r_hold  <= 1'b0;
                    end
                end
                RUN: begin
                    if (dn_active) begin
                        r_state  <= LOAD;
                        r_hold   <= 1'b1;
                        r_dn_ovf <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!dn_active) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                        r_hold    <= 1'b1;
                    end else if (dn_wr && w_dn_oor) begin
                        r_dn_ovf <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= CLEAR;
                    r_clr_cnt <= '0;
                    r_hold    <= 1'b1;
                end
            endcase
        end
    end

    // Read outputs stay at zero until the first clock after reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= 1'b1;
        end
    end

    // Bank index travels with the BRAM read so the output mux lines up with its data
    always_ff @(posedge Clock) begin
        r_rom_idx <= Addr[15:BANK_AW];
    end

    // ROM banks: write port from the download stream, read port from the CPU
    for (genvar b = 0; b < ROM_BANKS; b++) begin : g_rom
        assign w_bank_we[b] = (r_state == LOAD) && dn_wr && !w_dn_oor &&
                              (dn_addr[15:BANK_AW] == IDX_W'(b));

        mw_dpram_bank #(
            .AW (BANK_AW)
        ) u_bank (
            .i_clk   (Clock),
            .i_we    (w_bank_we[b]),
            .i_waddr (dn_addr[BANK_AW-1:0]),
            .i_wdata (dn_data),
            .i_raddr (Addr[BANK_AW-1:0]),
            .o_rdata (w_rom_q[b])
        );
    end

    // Select the registered bank; indices past the last bank read as zero
    always_comb begin
        w_rom_sel = 8'h00;
        for (int unsigned b = 0; b < ROM_BANKS; b++) begin
            if (r_rom_idx == IDX_W'(b)) begin
                w_rom_sel = w_rom_q[b];
            end
        end
    end

    assign Rom_out = r_rd_vld ? w_rom_sel : 8'h00;

    // RAM write port: the clear sweep owns it in CLEAR, the CPU only in RUN
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = Ram_Addr[RAM_AW-1:0];
        w_ram_wdata = Ram_in;
        case (r_state)
            CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_clr_cnt;
                w_ram_wdata = CLEAR_VAL;
            end
            RUN: begin
                w_ram_we = !RW_n;
            end
            default: begin
                w_ram_we = 1'b0;
            end
        endcase
    end

    mw_dpram_bank #(
        .AW (RAM_AW)
    ) u_ram (
        .i_clk   (Clock),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (Ram_Addr[RAM_AW-1:0]),
        .o_rdata (w_ram_q)
    );

    assign Ram_out = r_rd_vld ? w_ram_q : 8'h00;
    assign Hold    = r_hold;
    assign dn_ovf  = r_dn_ovf;

endmodule

// File: tb/tb_mw8080_memory_dl.sv
// Bench for mw8080_memory_dl (ROM_BANKS=3, BANK_AW=11, RAM_AW=13).
// Read expectations are queued when an address is driven and popped one cycle later.
module tb_mw8080_memory_dl;

    logic        clk = 1'b0;
    logic        Reset;
    logic        RW_n;
    logic [15:0] Addr;
    logic [15:0] Ram_Addr;
    logic [7:0]  Ram_in;
    logic [7:0]  Ram_out;
    logic [7:0]  Rom_out;
    logic        dn_active;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        Hold;
    logic        dn_ovf;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t rom_q[$];
    exp_t ram_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mw8080_memory_dl #(
        .ROM_BANKS (3),
        .BANK_AW   (11),
        .RAM_AW    (13),
        .CLEAR_VAL (8'h00)
    ) dut (
        .Clock     (clk),
        .Reset     (Reset),
        .RW_n      (RW_n),
        .Addr      (Addr),
        .Ram_Addr  (Ram_Addr),
        .Ram_in    (Ram_in),
        .Ram_out   (Ram_out),
        .Rom_out   (Rom_out),
        .dn_active (dn_active),
        .dn_wr     (dn_wr),
        .dn_addr   (dn_addr),
        .dn_data   (dn_data),
        .Hold      (Hold),
        .dn_ovf    (dn_ovf)
    );

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: compares read data one cycle after the address was driven
    always @(posedge clk) begin
        #1;
        if (rom_q.size() > 0) begin
            mon_e = rom_q.pop_front();
            chk_val(mon_e.tag, {24'd0, Rom_out}, {24'd0, mon_e.exp});
        end
        if (ram_q.size() > 0) begin
            mon_e = ram_q.pop_front();
            chk_val(mon_e.tag, {24'd0, Ram_out}, {24'd0, mon_e.exp});
        end
    end

    task automatic rom_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        @(negedge clk);
        Addr = a;
        rom_q.push_back('{tag, exp});
    endtask

    task automatic ram_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        @(negedge clk);
        RW_n     = 1'b1;
        Ram_Addr = a;
        ram_q.push_back('{tag, exp});
    endtask

    task automatic ram_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        RW_n     = 1'b0;
        Ram_Addr = a;
        Ram_in   = d;
        @(negedge clk);
        RW_n     = 1'b1;
    endtask

    task automatic dl_byte(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        @(negedge clk);
        dn_wr   = 1'b0;
    endtask

    task automatic enter_load(input string tag);
        @(negedge clk);
        dn_active = 1'b1;
        @(negedge clk);
        chk_val(tag, {31'd0, Hold}, 32'd1);
    endtask

    // Counts rising edges until Hold drops, bounded so the run always ends
    task automatic wait_hold_low(input string tag, input int start_n, input int exp_n);
        int n;
        n = start_n;
        while (Hold === 1'b1 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_val(tag, n, exp_n);
    endtask

    initial begin
        Reset     = 1'b1;
        RW_n      = 1'b1;
        Addr      = 16'h0000;
        Ram_Addr  = 16'h0000;
        Ram_in    = 8'h00;
        dn_active = 1'b0;
        dn_wr     = 1'b0;
        dn_addr   = 16'h0000;
        dn_data   = 8'h00;

        #1;
        chk_val("rst_hold",    {31'd0, Hold},    32'd1);
        chk_val("rst_ovf",     {31'd0, dn_ovf},  32'd0);
        chk_val("rst_rom_out", {24'd0, Rom_out}, 32'd0);
        chk_val("rst_ram_out", {24'd0, Ram_out}, 32'd0);

        // Power-on clear; a CPU write at 0x0020 after the sweep passed it must be dropped
        @(negedge clk);
        Reset = 1'b0;
        repeat (100) @(negedge clk);
        RW_n     = 1'b0;
        Ram_Addr = 16'h0020;
        Ram_in   = 8'h5A;
        @(negedge clk);
        RW_n = 1'b1;
        wait_hold_low("por_hold_cycles", 101, 8192);

        // RAM mirror write/read and the held write
        ram_wr(16'h2010, 8'h5A);
        ram_rd("ram_mirror_0010", 16'h0010, 8'h5A);
        ram_rd("ram_held_wr_0020", 16'h0020, 8'h00);
        ram_rd("ram_rbw_old", 16'h0030, 8'h00);
        ram_wr(16'h1FFF, 8'h11);
        ram_wr(16'h0000, 8'h22);
        ram_rd("ram_top_1fff", 16'h1FFF, 8'h11);
        ram_rd("ram_bot_0000", 16'h0000, 8'h22);

        // First download; Hold covers LOAD plus the full re-clear
        enter_load("load_hold");
        dl_byte(16'h0000, 8'hA5);
        dl_byte(16'h0800, 8'h3C);
        dl_byte(16'h1000, 8'hC3);
        dl_byte(16'h17FF, 8'h77);
        dn_active = 1'b0;
        wait_hold_low("load_clear_hold_cycles", 0, 8193);
        chk_val("load_no_ovf", {31'd0, dn_ovf}, 32'd0);

        // Every RAM location must be clear after the download
        for (int i = 0; i < 8192; i++) begin
            ram_rd("ram_cleared", i[15:0], 8'h00);
        end

        // ROM reads, including back-to-back bank alternation and out-of-range
        rom_rd("rom_0000", 16'h0000, 8'hA5);
        rom_rd("rom_0800", 16'h0800, 8'h3C);
        rom_rd("rom_alt_0000", 16'h0000, 8'hA5);
        rom_rd("rom_alt_0800", 16'h0800, 8'h3C);
        rom_rd("rom_alt_0000b", 16'h0000, 8'hA5);
        rom_rd("rom_17ff", 16'h17FF, 8'h77);
        rom_rd("rom_1800_oor", 16'h1800, 8'h00);
        rom_rd("rom_1000", 16'h1000, 8'hC3);
        rom_rd("rom_f800_oor", 16'hF800, 8'h00);
        rom_rd("rom_0800b", 16'h0800, 8'h3C);

        // dn_wr outside LOAD must not touch ROM
        dl_byte(16'h0000, 8'hEE);
        rom_rd("rom_dnwr_run_ignored", 16'h0000, 8'hA5);

        // Overflowing download: flag set, banks untouched, flag sticky into RUN
        enter_load("ovf_load_hold");
        chk_val("ovf_clear_on_entry", {31'd0, dn_ovf}, 32'd0);
        dl_byte(16'h1800, 8'hFF);
        chk_val("ovf_set", {31'd0, dn_ovf}, 32'd1);
        dn_active = 1'b0;
        wait_hold_low("ovf_clear_hold_cycles", 0, 8193);
        chk_val("ovf_sticky", {31'd0, dn_ovf}, 32'd1);
        rom_rd("ovf_rom_0000", 16'h0000, 8'hA5);
        rom_rd("ovf_rom_0800", 16'h0800, 8'h3C);
        rom_rd("ovf_rom_1000", 16'h1000, 8'hC3);

        // Re-entering LOAD clears the flag; then reset in the middle of a download
        enter_load("reload_hold");
        chk_val("ovf_cleared_reload", {31'd0, dn_ovf}, 32'd0);
        dl_byte(16'h0001, 8'h99);
        #2;
        Reset = 1'b1;
        #1;
        chk_val("midload_rst_hold", {31'd0, Hold}, 32'd1);
        chk_val("midload_rst_rom_out", {24'd0, Rom_out}, 32'd0);
        @(negedge clk);
        dn_active = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
        wait_hold_low("midload_rst_hold_cycles", 0, 8192);
        rom_rd("kept_0000", 16'h0000, 8'hA5);
        rom_rd("kept_0001", 16'h0001, 8'h99);
        rom_rd("kept_17ff", 16'h17FF, 8'h77);
        ram_rd("post_rst_ram_0010", 16'h0010, 8'h00);

        repeat (3) @(negedge clk);
        chk_val("scoreboard_drained", rom_q.size() + ram_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
